// File: rtl/edge_detect_pkg.sv
// Shared definitions for the edge detect / pulse stretch block: mode encodings
// and legal parameter ranges.
package edge_detect_pkg;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    localparam int WIDTH_MIN       = 1;
    localparam int WIDTH_MAX       = 32;
    localparam int SYNC_STAGES_MIN = 0;
    localparam int SYNC_STAGES_MAX = 3;

endpackage

// File: rtl/edge_stretch_channel.sv
// One channel: input synchroniser, history flop, mode-qualified edge detect,
// stretch down-counter and sticky event/overrun flags.
module edge_stretch_channel
    import edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH_W   = 4
) (
    input  logic                 clk,
    input  logic                 ares_n,
    input  logic                 sres,
    input  logic                 ld_en,
    input  logic [1:0]           mode,
    input  logic [STRETCH_W-1:0] stretch_len,
    input  logic                 level,
    input  logic                 flag_clr,
    output logic                 pulse,
    output logic                 event_flag,
    output logic                 overrun_flag
);

    logic                 s;
    logic                 h_q, h_d;
    logic                 act_q, act_d;
    logic [STRETCH_W-1:0] cnt_q, cnt_d;
    logic                 evt_q, evt_d;
    logic                 ovr_q, ovr_d;
    logic                 rise, fall, edge_det;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = level;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q, sync_d;

        always_comb begin
            sync_d = sync_q;
            if (ld_en) begin
                sync_d[0] = level;
                for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
            end
            if (sres) sync_d = '0;
        end

        always_ff @(posedge clk or negedge ares_n) begin
            if (!ares_n) sync_q <= '0;
            else         sync_q <= sync_d;
        end

        assign s = sync_q[SYNC_STAGES-1];
    end

    assign rise = s & ~h_q;
    assign fall = ~s & h_q;

    always_comb begin
        edge_det = 1'b0;
        case (mode_e'(mode))
            MODE_RISE: edge_det = rise;
            MODE_FALL: edge_det = fall;
            MODE_BOTH: edge_det = rise | fall;
            default:   edge_det = 1'b0;
        endcase
        edge_det = edge_det & ld_en;
    end

    always_comb begin
        h_d   = ld_en ? s : h_q;
        act_d = act_q;
        cnt_d = cnt_q;
        // A retrigger reloads the counter so the pulse extends with no low gap.
        if (edge_det) begin
            act_d = 1'b1;
            cnt_d = stretch_len;
        end else if (act_q) begin
            if (cnt_q == '0) act_d = 1'b0;
            else             cnt_d = cnt_q - STRETCH_W'(1);
        end
        evt_d = edge_det | (evt_q & ~flag_clr);
        ovr_d = (edge_det & act_q) | (ovr_q & ~flag_clr);
        if (sres) begin
            h_d   = 1'b0;
            act_d = 1'b0;
            cnt_d = '0;
            evt_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge ares_n) begin
        if (!ares_n) begin
            h_q   <= 1'b0;
            act_q <= 1'b0;
            cnt_q <= '0;
            evt_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            h_q   <= h_d;
            act_q <= act_d;
            cnt_q <= cnt_d;
            evt_q <= evt_d;
            ovr_q <= ovr_d;
        end
    end

    assign pulse        = act_q;
    assign event_flag   = evt_q;
    assign overrun_flag = ovr_q;

endmodule

// File: rtl/edge_detect_stretch.sv
// Multi-channel edge detector with pulse stretching; WIDTH independent
// channels sharing mode, stretch length and enables.
module edge_detect_stretch
    import edge_detect_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH_W   = 4
) (
    input  logic                 clk,
    input  logic                 ares_n,
    input  logic                 sres,
    input  logic                 ld_en,
    input  logic [1:0]           mode,
    input  logic [STRETCH_W-1:0] stretch_len,
    input  logic [WIDTH-1:0]     Level_In,
    input  logic [WIDTH-1:0]     flag_clr,
    output logic [WIDTH-1:0]     Pulse_Out,
    output logic [WIDTH-1:0]     Event_Flag,
    output logic [WIDTH-1:0]     Overrun_Flag
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        edge_stretch_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .STRETCH_W   (STRETCH_W)
        ) u_ch (
            .clk          (clk),
            .ares_n       (ares_n),
            .sres         (sres),
            .ld_en        (ld_en),
            .mode         (mode),
            .stretch_len  (stretch_len),
            .level        (Level_In[g]),
            .flag_clr     (flag_clr[g]),
            .pulse        (Pulse_Out[g]),
            .event_flag   (Event_Flag[g]),
            .overrun_flag (Overrun_Flag[g])
        );
    end

endmodule

// File: tb/tb_edge_detect_stretch.sv
// Scoreboarded bench for edge_detect_stretch: expected Pulse_Out per cycle is
// queued when stimulus is applied and compared as the cycles elapse.
module tb_edge_detect_stretch;
    localparam int W  = 8;
    localparam int SS = 2;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          ares_n = 1'b0;
    logic          sres = 1'b0;
    logic          ld_en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [SW-1:0] stretch_len = 4'd3;
    logic [W-1:0]  Level_In = '0;
    logic [W-1:0]  flag_clr = '0;
    logic [W-1:0]  Pulse_Out, Event_Flag, Overrun_Flag;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;

    always #5 clk = ~clk;

    edge_detect_stretch #(.WIDTH(W), .SYNC_STAGES(SS), .STRETCH_W(SW)) dut (
        .clk          (clk),
        .ares_n       (ares_n),
        .sres         (sres),
        .ld_en        (ld_en),
        .mode         (mode),
        .stretch_len  (stretch_len),
        .Level_In     (Level_In),
        .flag_clr     (flag_clr),
        .Pulse_Out    (Pulse_Out),
        .Event_Flag   (Event_Flag),
        .Overrun_Flag (Overrun_Flag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic clear_flags();
        flag_clr = '1;
        tick();
        flag_clr = '0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (Pulse_Out !== '0) begin n_err++; $display("FAIL reset_pulse: got %h want 00", Pulse_Out); end
        n_cmp++; if (Event_Flag !== '0) begin n_err++; $display("FAIL reset_event: got %h want 00", Event_Flag); end
        n_cmp++; if (Overrun_Flag !== '0) begin n_err++; $display("FAIL reset_overrun: got %h want 00", Overrun_Flag); end
        tick(); tick();
        #1 ares_n = 1'b1;
    endtask

    task automatic test_latency();
        ld_en = 1'b1; mode = 2'b00; stretch_len = 4'd3;
        tick(); tick(); tick();
        Level_In = 8'h01;
        push(8'h00, 2); push(8'h01, 4); push(8'h00, 2);
        while (exp_q.size() > 0) begin
            tick(); e = exp_q.pop_front(); n_cmp++;
            if (Pulse_Out !== e) begin n_err++; $display("FAIL latency_pulse: got %h want %h", Pulse_Out, e); end
        end
        n_cmp++; if (Event_Flag !== 8'h01) begin n_err++; $display("FAIL latency_event: got %h want 01", Event_Flag); end
        n_cmp++; if (Overrun_Flag !== 8'h00) begin n_err++; $display("FAIL latency_overrun: got %h want 00", Overrun_Flag); end
        Level_In = 8'h00;
        push(8'h00, 4);
        while (exp_q.size() > 0) begin
            tick(); e = exp_q.pop_front(); n_cmp++;
            if (Pulse_Out !== e) begin n_err++; $display("FAIL rise_ignores_fall: got %h want %h", Pulse_Out, e); end
        end
    endtask

    task automatic test_retrigger();
        clear_flags();
        mode = 2'b10; stretch_len = 4'd5;
        Level_In = 8'h04;
        tick();
        Level_In = 8'h00;
        // first edge sample already consumed above
        push(8'h00, 1); push(8'h04, 7); push(8'h00, 2);
        while (exp_q.size() > 0) begin
            tick(); e = exp_q.pop_front(); n_cmp++;
            if (Pulse_Out !== e) begin n_err++; $display("FAIL retrigger_pulse: got %h want %h", Pulse_Out, e); end
        end
        n_cmp++; if (Overrun_Flag !== 8'h04) begin n_err++; $display("FAIL retrigger_overrun: got %h want 04", Overrun_Flag); end
        n_cmp++; if (Event_Flag !== 8'h04) begin n_err++; $display("FAIL retrigger_event: got %h want 04", Event_Flag); end
    endtask

    task automatic test_enable();
        clear_flags();
        mode = 2'b00; stretch_len = 4'd3;
        ld_en = 1'b0; Level_In = 8'h02;
        push(8'h00, 10);
        while (exp_q.size() > 0) begin
            tick(); e = exp_q.pop_front(); n_cmp++;
            if (Pulse_Out !== e) begin n_err++; $display("FAIL disabled_pulse: got %h want %h", Pulse_Out, e); end
        end
        n_cmp++; if (Event_Flag !== 8'h00) begin n_err++; $display("FAIL disabled_event: got %h want 00", Event_Flag); end
        ld_en = 1'b1;
        push(8'h00, 2); push(8'h02, 4); push(8'h00, 2);
        while (exp_q.size() > 0) begin
            tick(); e = exp_q.pop_front(); n_cmp++;
            if (Pulse_Out !== e) begin n_err++; $display("FAIL enable_pulse: got %h want %h", Pulse_Out, e); end
        end
        Level_In = 8'h00;
        repeat (4) tick();
    endtask

    task automatic test_flag_race();
        // Event_Flag[1] remains set from the enable test.
        Level_In = 8'h08;
        push(8'h00, 2); push(8'h08, 4); push(8'h00, 2);
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) flag_clr = 8'h08;
            if (c == 5) flag_clr = 8'h00;
            tick(); e = exp_q.pop_front(); n_cmp++;
            if (Pulse_Out !== e) begin n_err++; $display("FAIL race_pulse: got %h want %h", Pulse_Out, e); end
            if (c == 3) begin
                n_cmp++; if (Event_Flag !== 8'h0A) begin n_err++; $display("FAIL race_set_wins: got %h want 0a", Event_Flag); end
            end
            if (c == 4) begin
                n_cmp++; if (Event_Flag !== 8'h02) begin n_err++; $display("FAIL race_clear: got %h want 02", Event_Flag); end
            end
        end
    endtask

    task automatic test_modes();
        clear_flags();
        mode = 2'b01; stretch_len = 4'd1;
        Level_In = 8'h00;
        push(8'h00, 2); push(8'h08, 2); push(8'h00, 2);
        while (exp_q.size() > 0) begin
            tick(); e = exp_q.pop_front(); n_cmp++;
            if (Pulse_Out !== e) begin n_err++; $display("FAIL fall_mode_pulse: got %h want %h", Pulse_Out, e); end
        end
        Level_In = 8'h08;
        push(8'h00, 6);
        while (exp_q.size() > 0) begin
            tick(); e = exp_q.pop_front(); n_cmp++;
            if (Pulse_Out !== e) begin n_err++; $display("FAIL fall_mode_rise: got %h want %h", Pulse_Out, e); end
        end
        clear_flags();
        mode = 2'b11;
        Level_In = 8'h10;
        push(8'h00, 6);
        while (exp_q.size() > 0) begin
            tick(); e = exp_q.pop_front(); n_cmp++;
            if (Pulse_Out !== e) begin n_err++; $display("FAIL off_mode_pulse: got %h want %h", Pulse_Out, e); end
        end
        n_cmp++; if (Event_Flag !== 8'h00) begin n_err++; $display("FAIL off_mode_event: got %h want 00", Event_Flag); end
        n_cmp++; if (Overrun_Flag !== 8'h00) begin n_err++; $display("FAIL off_mode_overrun: got %h want 00", Overrun_Flag); end
    endtask

    task automatic test_reset_mid();
        mode = 2'b00; stretch_len = 4'd3;
        Level_In = 8'h11;
        push(8'h00, 2); push(8'h01, 2);
        while (exp_q.size() > 0) begin
            tick(); e = exp_q.pop_front(); n_cmp++;
            if (Pulse_Out !== e) begin n_err++; $display("FAIL pre_reset_pulse: got %h want %h", Pulse_Out, e); end
        end
        #2 ares_n = 1'b0;
        #1;
        n_cmp++; if (Pulse_Out !== '0) begin n_err++; $display("FAIL midreset_pulse: got %h want 00", Pulse_Out); end
        n_cmp++; if (Event_Flag !== '0) begin n_err++; $display("FAIL midreset_event: got %h want 00", Event_Flag); end
        Level_In = 8'hFF;
        tick(); tick();
        #1 ares_n = 1'b1;
        push(8'h00, 2); push(8'hFF, 4); push(8'h00, 2);
        while (exp_q.size() > 0) begin
            tick(); e = exp_q.pop_front(); n_cmp++;
            if (Pulse_Out !== e) begin n_err++; $display("FAIL release_pulse: got %h want %h", Pulse_Out, e); end
        end
        n_cmp++; if (Event_Flag !== 8'hFF) begin n_err++; $display("FAIL release_event: got %h want ff", Event_Flag); end
    endtask

    task automatic test_sres();
        mode = 2'b10; stretch_len = 4'd7;
        Level_In = 8'h00;
        push(8'h00, 2); push(8'hFF, 2);
        while (exp_q.size() > 0) begin
            tick(); e = exp_q.pop_front(); n_cmp++;
            if (Pulse_Out !== e) begin n_err++; $display("FAIL pre_sres_pulse: got %h want %h", Pulse_Out, e); end
        end
        sres = 1'b1;
        tick();
        sres = 1'b0;
        n_cmp++; if (Pulse_Out !== '0) begin n_err++; $display("FAIL sres_pulse: got %h want 00", Pulse_Out); end
        n_cmp++; if (Event_Flag !== '0) begin n_err++; $display("FAIL sres_event: got %h want 00", Event_Flag); end
        n_cmp++; if (Overrun_Flag !== '0) begin n_err++; $display("FAIL sres_overrun: got %h want 00", Overrun_Flag); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_retrigger();
        test_enable();
        test_flag_race();
        test_modes();
        test_reset_mid();
        test_sres();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/edge_detect_stretch.md
EDGE_DETECT_STRETCH -- requirements
Module: edge_detect_stretch

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of independent channels (legal range 1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the input synchroniser depth (legal range 0..3; 0 means no synchroniser).
REQ-003 The block SHALL have parameter STRETCH_W, default 4, giving the width of the stretch-length field and the per-channel counters.

Ports (name, direction, width, meaning):
REQ-004 clk, in, 1: the single clock; all flops are rising-edge.
REQ-005 ares_n, in, 1: asynchronous active-low reset.
REQ-006 sres, in, 1: synchronous clear.
REQ-007 ld_en, in, 1: sampling enable.
REQ-008 mode, in, 2: detection mode; 00 rising, 01 falling, 10 both edges, 11 detection disabled.
REQ-009 stretch_len, in, STRETCH_W: pulse length is stretch_len+1 cycles.
REQ-010 Level_In, in, WIDTH: channel levels, possibly asynchronous to clk.
REQ-011 flag_clr, in, WIDTH: per-channel clear for the sticky flags.
REQ-012 Pulse_Out, out, WIDTH: registered, stretched edge pulses.
REQ-013 Event_Flag, out, WIDTH: sticky flag per channel, set on any detected edge.
REQ-014 Overrun_Flag, out, WIDTH: sticky flag per channel, set on a retrigger while the channel is already stretching.

Function
REQ-015 Per channel, Level_In SHALL pass through SYNC_STAGES flops and then one history flop.
- Both the synchroniser flops and the history flop advance only when ld_en=1; otherwise they hold.
REQ-016 Edge detection SHALL be combinational on the synchroniser output s and the history flop h:
- rise = s & ~h
- fall = ~s & h
- qualified by mode and by ld_en=1.
- mode=11 yields no edges.
REQ-017 Pulse_Out SHALL rise on the (SYNC_STAGES+1)th rising clk edge at which the changed Level_In is sampled with ld_en=1.
REQ-018 Pulse_Out SHALL then stay high for exactly stretch_len+1 cycles.
REQ-019 A qualified edge SHALL load the channel down-counter with stretch_len, sampled at that cycle.
- Pulse_Out is high while the counter is active.
- The counter decrements each cycle regardless of ld_en.
REQ-020 An edge arriving while a channel is active SHALL:
- restart the count from the current stretch_len, so the pulse is extended with no low gap;
- set that channel's Overrun_Flag.
REQ-021 Event_Flag[i] SHALL set on any qualified edge of channel i.
- Event_Flag[i] and Overrun_Flag[i] clear on flag_clr[i]=1.
- A set and a clear in the same cycle: set wins.
REQ-022 Changes to stretch_len or mode SHALL affect only edges detected after the change; pulses already in progress complete unchanged.
REQ-023 Channels SHALL be fully independent; simultaneous edges on all channels are all honoured in the same cycle.
REQ-024 sres=1 SHALL synchronously clear all flops, counters, outputs and flags, with priority over ld_en, flag_clr and edges.

Reset
REQ-025 ares_n=0 SHALL asynchronously clear all flops, giving:
- Pulse_Out=0
- Event_Flag=0
- Overrun_Flag=0
- counters idle
- synchroniser and history flops 0
REQ-026 Reset release SHALL be synchronous to clk; no edge is detected in the release cycle.
REQ-027 A Level_In held high through reset SHALL, after release with ld_en=1, produce one rising-edge pulse (history resets to 0).
- This behaviour is intentional.
REQ-028 Reset asserted mid-pulse SHALL terminate the pulse immediately, without waiting for a clock.

Structure
REQ-029 A shared package edge_detect_pkg SHALL hold the mode encodings (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_OFF) and the parameter range limits.
REQ-030 Per-channel logic SHALL be one sub-module, edge_stretch_channel, containing:
- synchroniser
- history flop
- edge qualify
- counter
- flags
It is instantiated WIDTH times via generate.
REQ-031 There SHALL be no combinational path from any input to any output.

Verification
REQ-032 Latency and length: WIDTH=8, SYNC_STAGES=2, mode=00, stretch_len=3, Level_In[0] 0->1 held -> Pulse_Out[0] high on clk edge 3 for exactly 4 cycles; Event_Flag[0]=1; other channels 0.
REQ-033 Retrigger: mode=10, stretch_len=5, Level_In[2] toggles on 2 consecutive cycles -> a single pulse of 7 cycles; Overrun_Flag[2]=1.
REQ-034 Enable gating: ld_en=0 while Level_In[1] 0->1, then ld_en=1 after 10 cycles -> no pulse during disable; one pulse SYNC_STAGES+1 edges after re-enable.
REQ-035 Flag race: flag_clr[3]=1 in the same cycle as a new edge on channel 3 -> Event_Flag[3] stays 1; flag_clr alone on the next cycle -> Event_Flag[3]=0.
REQ-036 Reset: ares_n=0 mid-pulse -> all outputs 0 immediately; on release with Level_In=8'hFF, mode=00 -> 8'hFF pulse of stretch_len+1 cycles.
REQ-037 Modes: mode=01, falling edge -> pulse; rising edge -> none; mode=11 -> no pulses and no flag changes.
